// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker.
// Seeds its shift register from the incoming stream, verifies the prediction
// for LOCK_COUNT bits, then free-runs and counts bit errors. Too many errors
// inside one observation window drop lock and restart seeding.
module prbs31_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int WIN_BITS    = 1024,
  parameter int LOSS_THRESH = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       sync_state
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Window counters must hold values up to WIN_BITS-1 and LOSS_THRESH-1.
  localparam int WIN_W = $clog2(WIN_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [30:0]        sr_q, sr_d;
  logic [4:0]         fill_cnt_q, fill_cnt_d;
  logic [7:0]         match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]   win_err_q, win_err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_q, locked_d;

  logic pred;
  logic mismatch;

  assign pred     = sr_q[30] ^ sr_q[27];
  assign mismatch = bit_in ^ pred;

  // Next-state logic: sync FSM, shift register, window and error counters.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (bit_valid) begin
      case (state_q)
        SEED: begin
          sr_d = {sr_q[29:0], bit_in};
          if (fill_cnt_q == 5'd30) begin
            // 31st bit: an all-zero register is the LFSR lock-up state, refill.
            fill_cnt_d = '0;
            if (sr_d != '0) begin
              state_d     = VERIFY;
              match_cnt_d = '0;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 5'd1;
          end
        end
        VERIFY: begin
          sr_d = {sr_q[29:0], bit_in};
          if (!mismatch) begin
            match_cnt_d = match_cnt_q + 8'd1;
            if (match_cnt_q == 8'(LOCK_COUNT - 1)) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            // Seed was wrong; demand a full refill before trying again.
            state_d    = SEED;
            fill_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a flipped bit is one error, not three.
          sr_d        = {sr_q[29:0], pred};
          err_pulse_d = mismatch;
          if (mismatch && (err_count_q != CNT_MAX))
            err_count_d = err_count_q + CNT_W'(1);
          if (mismatch && (win_err_q == WIN_W'(LOSS_THRESH - 1))) begin
            state_d    = SEED;
            fill_cnt_d = '0;
          end else if (win_cnt_q == WIN_W'(WIN_BITS - 1)) begin
            // Last bit of the window; its error was judged above, then restart.
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (mismatch) win_err_d = win_err_q + WIN_W'(1);
          end
        end
        default: begin
          state_d    = SEED;
          fill_cnt_d = '0;
        end
      endcase
    end

    // Clear beats a coincident increment.
    if (clr_cnt) err_count_d = '0;

    locked_d = (state_d == LOCKED);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEED;
      sr_q        <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign sync_state = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: stimulus pushes the expected outputs
// for each driven edge; a monitor pops and compares just after that edge.
module tb_prbs31_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic clr_cnt = 1'b0;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_count_a;
  logic [1:0]  sync_state_a;
  logic        locked_b, err_pulse_b;
  logic [3:0]  err_count_b;
  logic [1:0]  sync_state_b;

  always #5 clk = ~clk;

  prbs31_checker dut_a (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .clr_cnt(clr_cnt), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_count(err_count_a), .sync_state(sync_state_a)
  );

  prbs31_checker #(.CNT_W(4), .LOSS_THRESH(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .clr_cnt(clr_cnt), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_count(err_count_b), .sync_state(sync_state_b)
  );

  typedef struct {
    bit          sel;   // 0: default instance, 1: CNT_W=4 instance
    int          ph;
    bit          lk;
    bit          pl;
    logic [15:0] cnt;
    logic [1:0]  st;
    bit          mst;   // compare sync_state
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;
  bit   sel    = 1'b0;
  int   ec     = 0;
  logic [30:0] g = 31'h7FFFFFFF;

  task automatic chk(input string nm, input int ph, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s phase=%0d t=%0t got=%0h exp=%0h", nm, ph, $time, got, exp);
    end
  endtask

  // Monitor: one expectation per driven edge, compared 1 ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk("locked", e.ph, 16'(locked_a), 16'(e.lk));
          chk("err_pulse", e.ph, 16'(err_pulse_a), 16'(e.pl));
          chk("err_count", e.ph, err_count_a, e.cnt);
          if (e.mst) chk("sync_state", e.ph, 16'(sync_state_a), 16'(e.st));
        end else begin
          chk("locked_b", e.ph, 16'(locked_b), 16'(e.lk));
          chk("err_pulse_b", e.ph, 16'(err_pulse_b), 16'(e.pl));
          chk("err_count_b", e.ph, 16'(err_count_b), e.cnt);
          if (e.mst) chk("sync_state_b", e.ph, 16'(sync_state_b), 16'(e.st));
        end
      end
    end
  end

  function automatic exp_t mk(input bit lk, input bit pl, input int cnt, input int st, input bit mst);
    exp_t e;
    e.sel = sel; e.ph = phase; e.lk = lk; e.pl = pl;
    e.cnt = 16'(cnt); e.st = 2'(st); e.mst = mst;
    return e;
  endfunction

  // Expected sync_state after the i-th valid bit of a clean acquisition.
  function automatic int sched(input int i);
    return (i < 31) ? 0 : ((i < 95) ? 1 : 2);
  endfunction

  task automatic next_bit(output bit o);
    o = g[30] ^ g[27];
    g = {g[29:0], o};
  endtask

  task automatic drive(input bit rst, input bit v, input bit b, input bit clr, input exp_t e);
    @(negedge clk);
    rst_n = rst; bit_valid = v; bit_in = b; clr_cnt = clr;
    q.push_back(e);
  endtask

  task automatic do_reset();
    ec = 0;
    repeat (2) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, mk(0, 0, 0, 0, 1));
  endtask

  // 95 clean valid bits from SEED: lock on the 95th.
  task automatic relock();
    bit b;
    for (int i = 1; i <= 95; i++) begin
      next_bit(b);
      drive(1'b1, 1'b1, b, 1'b0, mk(i >= 95, 0, ec, sched(i), 1));
    end
  endtask

  initial begin
    bit b, err, lost, v, clr;
    int vc;

    // Reset state
    phase = 0; sel = 0;
    do_reset();

    // 1: clean stream, lock at bit 95, no errors over 10000 bits
    phase = 1;
    for (int i = 1; i <= 10000; i++) begin
      next_bit(b);
      drive(1'b1, 1'b1, b, 1'b0, mk(i >= 95, 0, 0, sched(i), 1));
    end

    // 2: one inverted bit -> single pulse, count 1, lock held
    phase = 2;
    for (int i = 1; i <= 200; i++) begin
      next_bit(b);
      err = (i == 50);
      if (err) ec = 1;
      drive(1'b1, 1'b1, b ^ err, 1'b0, mk(1, err, ec, 2, 1));
    end

    // 3a: 16 errors in one window -> loss on the 16th, then relock
    phase = 3;
    do_reset();
    relock();
    for (int j = 0; j <= 160; j++) begin
      next_bit(b);
      err  = (j > 0) && (j % 10 == 0);
      lost = (j == 160);
      if (err) ec++;
      drive(1'b1, 1'b1, b ^ err, 1'b0, mk(!lost, err, ec, lost ? 0 : 2, 1));
    end
    relock();

    // 3b: clear, then 15 errors ending on the last window bit, 15 at the start of the next
    phase = 4;
    for (int j = 0; j <= 1200; j++) begin
      next_bit(b);
      clr = (j == 0);
      if (clr) ec = 0;
      err = ((j % 10 == 0) && (j >= 10) && (j <= 140)) || (j == 1023) || ((j >= 1024) && (j <= 1038));
      if (err) ec++;
      drive(1'b1, 1'b1, b ^ err, clr, mk(1, err, ec, 2, 1));
    end

    // 4: zeros never leave SEED; a stream with every 20th bit flipped never locks
    phase = 5;
    do_reset();
    for (int i = 1; i <= 200; i++)
      drive(1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 1));
    for (int i = 1; i <= 200; i++) begin
      next_bit(b);
      drive(1'b1, 1'b1, b ^ (i % 20 == 0), 1'b0, mk(0, 0, 0, 0, 0));
    end

    // 5: bit_valid every other cycle; then clear coinciding with an error
    phase = 6;
    do_reset();
    vc = 0;
    for (int c = 1; c <= 230; c++) begin
      v = c[0];
      err = 1'b0;
      clr = 1'b0;
      if (v) begin
        next_bit(b);
        vc++;
        err = (c == 211) || (c == 221);
        clr = (c == 221);
        if (err) ec++;
        if (clr) ec = 0;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      drive(1'b1, v, b ^ err, clr, mk(vc >= 95, err, ec, sched(vc), 1));
    end

    // 6: 4-bit counter saturates at 15; reset mid-lock clears everything
    phase = 7; sel = 1;
    do_reset();
    relock();
    for (int j = 0; j <= 150; j++) begin
      next_bit(b);
      err = (j > 0) && (j % 5 == 0) && (j <= 100);
      if (err && ec < 15) ec++;
      drive(1'b1, 1'b1, b ^ err, 1'b0, mk(1, err, ec, 2, 1));
    end
    next_bit(b);
    drive(1'b0, 1'b1, ~b, 1'b0, mk(0, 0, 0, 0, 1));
    drive(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1));

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
